// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: redirect request, instruction memory port and decode-side handshake.
// master = fetch queue, slave = surrounding core (decode, branch unit, imem).
interface fetch_queue_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_instr;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic [CNT_W-1:0]      count;

   modport master (
      input  redirect, redirect_pc, imem_rdata, out_ready,
      output imem_addr, out_valid, out_instr, out_pc, count
   );

   modport slave (
      output redirect, redirect_pc, imem_rdata, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, drives a combinational imem and
// buffers up to DEPTH {pc, instr} pairs for decode; redirect flushes and re-steers.
module fetch_queue #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   entry_t                storage [DEPTH];
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count_q;

   logic   valid_c;
   logic   pop_c;
   logic   push_c;
   entry_t head_c;

   // Push-while-full is legal only when the head leaves in the same cycle.
   assign valid_c = (count_q != '0);
   assign pop_c   = valid_c & bus.out_ready;
   assign push_c  = ~bus.redirect & ((count_q < CNT_W'(DEPTH)) | pop_c);
   assign head_c  = storage[rd_ptr];

   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = valid_c;
   assign bus.out_instr = head_c.instr;
   assign bus.out_pc    = head_c.pc;
   assign bus.count     = count_q;

   // Control state: reset beats redirect, redirect beats push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
      end else if (bus.redirect) begin
         fetch_pc <= bus.redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_c && !pop_c) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // Payload storage needs no reset; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (!rst && push_c) begin
         storage[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_rdata};
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count_q <= CNT_W'(DEPTH));

   a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
      PTR_W'(count_q) == PTR_W'(wr_ptr - rd_ptr));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues expected {pc, instr} pairs,
// a negedge monitor retires them against every accepted head entry.
module tb_fetch_queue;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   fetch_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory: word = 0x1000_0000 | addr.
   assign bus.imem_rdata = 32'h1000_0000 | bus.imem_addr;

   int unsigned vectors = 0;
   int unsigned errors  = 0;
   logic [63:0] exp_q [$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_run(input logic [31:0] start, input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] pc;
         pc = start + 32'(4 * k);
         exp_q.push_back({pc, 32'h1000_0000 | pc});
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.redirect = 1'b0;
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Monitor: every handshake the consumer completes must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_pop: got pc 0x%0h, expected no entry at %0t", bus.out_pc, $time);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("pop_pc", bus.out_pc, e[63:32]);
            chk("pop_instr", bus.out_instr, e[31:0]);
         end
      end
   end

   initial begin
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = 1'b0;
      tick();
      do_reset();
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'h0);

      // Streaming with out_ready held high.
      expect_run(32'h0, 16);
      bus.out_ready = 1'b1;
      tick();
      chk("first_valid", 32'(bus.out_valid), 32'd1);
      chk("first_pc", bus.out_pc, 32'h0);
      repeat (4) tick();
      bus.out_ready = 1'b0;
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_imem_addr", bus.imem_addr, 32'h14);
      chk("stream_pops", 32'(exp_q.size()), 32'd12);

      // Fill to full with out_ready low, then one pop with same-cycle push.
      do_reset();
      expect_run(32'h0, 16);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("fill_count", 32'(bus.count), 32'(k));
      end
      repeat (2) tick();
      chk("full_hold_count", 32'(bus.count), 32'd4);
      chk("full_imem_addr", bus.imem_addr, 32'h10);
      chk("full_head_pc", bus.out_pc, 32'h0);
      chk("full_head_instr", bus.out_instr, 32'h1000_0000);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("full_pop_count", 32'(bus.count), 32'd4);
      chk("full_pop_head", bus.out_pc, 32'h4);
      chk("full_pop_imem_addr", bus.imem_addr, 32'h14);
      chk("full_pop_retired", 32'(exp_q.size()), 32'd15);

      // Redirect with three entries queued.
      do_reset();
      repeat (3) tick();
      chk("pre_redir_count", 32'(bus.count), 32'd3);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h200;
      tick();
      bus.redirect = 1'b0;
      exp_q.delete();
      expect_run(32'h200, 32);
      chk("redir_count", 32'(bus.count), 32'd0);
      chk("redir_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_imem_addr", bus.imem_addr, 32'h200);
      tick();
      chk("redir_head_valid", 32'(bus.out_valid), 32'd1);
      chk("redir_head_pc", bus.out_pc, 32'h200);
      chk("redir_head_instr", bus.out_instr, 32'h1000_0200);

      // Redirect coinciding with a pop on a full queue.
      repeat (3) tick();
      chk("refill_count", 32'(bus.count), 32'd4);
      chk("refill_imem_addr", bus.imem_addr, 32'h210);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h300;
      bus.out_ready   = 1'b1;
      tick();
      bus.redirect  = 1'b0;
      bus.out_ready = 1'b0;
      exp_q.delete();
      expect_run(32'h300, 32);
      chk("redir_pop_count", 32'(bus.count), 32'd0);
      chk("redir_pop_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_pop_imem_addr", bus.imem_addr, 32'h300);
      tick();
      chk("redir_pop_count1", 32'(bus.count), 32'd1);
      chk("redir_pop_head", bus.out_pc, 32'h300);

      // Alternate out_ready across pointer wrap; monitor checks pc continuity.
      for (int i = 0; i < 20; i++) begin
         bus.out_ready = (i % 2 == 0);
         tick();
         vectors++;
         if (bus.count > 3'(DEPTH)) begin
            errors++;
            $display("FAIL wrap_count_bound: got %0d, expected <= %0d", bus.count, DEPTH);
         end
      end
      bus.out_ready = 1'b0;
      chk("wrap_end_count", 32'(bus.count), 32'd4);
      chk("wrap_pops", 32'(exp_q.size()), 32'd22);

      // Reset wins over a simultaneous redirect.
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h500;
      tick();
      bus.redirect = 1'b0;
      exp_q.delete();
      repeat (2) tick();
      chk("pre_rst_count", 32'(bus.count), 32'd2);
      chk("pre_rst_head", bus.out_pc, 32'h500);
      rst             = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h700;
      tick();
      rst          = 1'b0;
      bus.redirect = 1'b0;
      chk("rst_redir_count", 32'(bus.count), 32'd0);
      chk("rst_redir_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_redir_imem_addr", bus.imem_addr, 32'h0);
      tick();
      chk("rst_redir_head_pc", bus.out_pc, 32'h0);
      chk("rst_redir_count1", 32'(bus.count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
